// File: rtl/gb_timer_bank.sv
// Bank of NUM_CH DMG-style TIMA/TMA/TAC timers sharing one free-running system counter (DIV).
// Define TIMER_IRQ_STATUS_EN to add a sticky write-1-to-clear irq status register at BASE+1.
module gb_timer_bank #(
    parameter int          NUM_CH     = 2,
    parameter int          SYS_W      = 16,
    parameter logic [15:0] BASE_ADDR  = 16'hFF04,
    parameter int          RELOAD_DLY = 4,
    parameter int          SYS_RST    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       addr,
    input  logic              we,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    output logic [NUM_CH-1:0] irq
);

    typedef enum logic [1:0] {
        ST_COUNT,
        ST_DELAY,
        ST_RELOAD
    } state_t;

    localparam int         WIN      = 4 + 4 * NUM_CH;
    localparam logic [2:0] DLY_INIT = 3'(RELOAD_DLY);

    logic [SYS_W-1:0] sys;
    logic [15:0]      offset;
    logic [2:0]       ch_idx;
    logic             in_win;
    logic             div_hit;
    logic             ch_hit;
    logic             div_wr;
    logic             ch_we;

    logic [7:0] tima_rd [NUM_CH];
    logic [7:0] tma_rd  [NUM_CH];
    logic [2:0] tac_rd  [NUM_CH];

    // Address decode relative to DIV; channel registers start at offset 4.
    assign offset  = addr - BASE_ADDR;
    assign in_win  = offset < 16'(WIN);
    assign div_hit = offset == 16'd0;
    assign ch_hit  = in_win && (offset >= 16'd4);
    assign ch_idx  = 3'((offset - 16'd4) >> 2);
    assign div_wr  = we && div_hit;
    assign ch_we   = we && ch_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            sys <= SYS_W'(SYS_RST);
        end else if (div_wr) begin
            sys <= '0;
        end else begin
            sys <= sys + SYS_W'(1);
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        state_t     state, state_nx;
        logic [7:0] tima, tima_nx;
        logic [7:0] tma, tma_nx;
        logic [2:0] tac;
        logic [2:0] dly, dly_nx;
        logic       prev_sel, prev_en;
        logic       cur_sel, cur_en;
        logic       tick;
        logic       irq_q, irq_nx;
        logic       tima_wr, tma_wr, tac_wr;

        assign tima_wr = ch_we && (ch_idx == 3'(n)) && (offset[1:0] == 2'd0);
        assign tma_wr  = ch_we && (ch_idx == 3'(n)) && (offset[1:0] == 2'd1);
        assign tac_wr  = ch_we && (ch_idx == 3'(n)) && (offset[1:0] == 2'd2);
        assign tma_nx  = tma_wr ? wdata : tma;

        always_comb begin
            cur_sel = sys[9];
            unique case (tac[1:0])
                2'b01:   cur_sel = sys[3];
                2'b10:   cur_sel = sys[5];
                2'b11:   cur_sel = sys[7];
                default: cur_sel = sys[9];
            endcase
        end

        assign cur_en = tac[2];
        // Falling edge of (tap & enable): DIV resets, mode changes and disables can glitch a tick.
        assign tick   = prev_sel && prev_en && !(cur_sel && cur_en);

        // dly counts the 0x00 cycles still to show after an overflow, the RELOAD cycle included.
        always_comb begin
            // NOTE: every output gets a default before the case so no path can infer a latch.
            state_nx = state;
            tima_nx  = tima;
            dly_nx   = dly;
            irq_nx   = 1'b0;
            unique case (state)
                ST_COUNT: begin
                    if (tima_wr) begin
                        tima_nx = wdata;
                    end else if (tick) begin
                        if (tima != 8'hFF) begin
                            tima_nx = tima + 8'd1;
                        end else if (RELOAD_DLY == 0) begin
                            tima_nx = tma_nx;
                            irq_nx  = 1'b1;
                        end else begin
                            tima_nx  = 8'h00;
                            dly_nx   = DLY_INIT;
                            state_nx = (RELOAD_DLY == 1) ? ST_RELOAD : ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    if (tima_wr) begin
                        tima_nx  = wdata;
                        dly_nx   = 3'd0;
                        state_nx = ST_COUNT;
                    end else begin
                        dly_nx = dly - 3'd1;
                        if (dly <= 3'd2) begin
                            state_nx = ST_RELOAD;
                        end
                    end
                end
                ST_RELOAD: begin
                    tima_nx  = tma_nx;
                    dly_nx   = 3'd0;
                    irq_nx   = 1'b1;
                    state_nx = ST_COUNT;
                end
                default: state_nx = ST_COUNT;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state    <= ST_COUNT;
                tima     <= 8'h00;
                tma      <= 8'h00;
                tac      <= 3'd0;
                dly      <= 3'd0;
                prev_sel <= 1'b0;
                prev_en  <= 1'b0;
                irq_q    <= 1'b0;
            end else begin
                // NOTE: non-blocking throughout so every register samples the same pre-edge values.
                state    <= state_nx;
                tima     <= tima_nx;
                tma      <= tma_nx;
                tac      <= tac_wr ? wdata[2:0] : tac;
                dly      <= dly_nx;
                prev_sel <= cur_sel;
                prev_en  <= cur_en;
                irq_q    <= irq_nx;
            end
        end

        assign irq[n]     = irq_q;
        assign tima_rd[n] = tima;
        assign tma_rd[n]  = tma;
        assign tac_rd[n]  = tac;
    end

`ifdef TIMER_IRQ_STATUS_EN
    logic              stat_hit;
    logic [NUM_CH-1:0] status;
    logic [NUM_CH-1:0] clr_mask;
    logic [7:0]        stat_rd;

    assign stat_hit = offset == 16'd1;
    assign clr_mask = (we && stat_hit) ? wdata[NUM_CH-1:0] : '0;

    // A pulse in the same cycle as a clear keeps its bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            status <= '0;
        end else begin
            status <= (status & ~clr_mask) | irq;
        end
    end

    always_comb begin
        stat_rd               = 8'hFF;
        stat_rd[NUM_CH-1:0]   = status;
    end
`endif

    always_comb begin
        rdata = 8'hAA;
        if (in_win) begin
            rdata = 8'hFF;
            if (div_hit) begin
                rdata = sys[SYS_W-1 -: 8];
            end
`ifdef TIMER_IRQ_STATUS_EN
            if (stat_hit) begin
                rdata = stat_rd;
            end
`endif
            if (ch_hit) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_idx == 3'(i)) begin
                        unique case (offset[1:0])
                            2'd0:    rdata = tima_rd[i];
                            2'd1:    rdata = tma_rd[i];
                            2'd2:    rdata = {5'b11111, tac_rd[i]};
                            default: rdata = 8'hFF;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gb_timer_bank.sv
// Directed bench for gb_timer_bank: stimulus pushes expected read data/irq into a scoreboard queue,
// a negedge monitor pops and compares whenever a checked read cycle is presented.
module tb_gb_timer_bank;

    localparam int          NUM_CH  = 2;
    localparam int          SYS_RST = 4;
    localparam logic [15:0] A_DIV   = 16'hFF04;
    localparam logic [15:0] A_STAT  = 16'hFF05;
    localparam logic [15:0] A_TIMA0 = 16'hFF08;
    localparam logic [15:0] A_TMA0  = 16'hFF09;
    localparam logic [15:0] A_TAC0  = 16'hFF0A;
    localparam logic [15:0] A_TIMA1 = 16'hFF0C;
    localparam logic [15:0] A_TMA1  = 16'hFF0D;
    localparam logic [15:0] A_TAC1  = 16'hFF0E;
`ifdef TIMER_IRQ_STATUS_EN
    localparam logic [7:0]  STAT_RST = 8'hFC;
    localparam logic [7:0]  STAT_CLR = 8'hFE;
`else
    localparam logic [7:0]  STAT_RST = 8'hFF;
    localparam logic [7:0]  STAT_CLR = 8'hFF;
`endif

    typedef struct {
        string             name;
        logic [7:0]        data;
        logic [NUM_CH-1:0] irq;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [15:0]       addr;
    logic              we;
    logic [7:0]        wdata;
    logic [7:0]        rdata;
    logic [NUM_CH-1:0] irq;

    exp_t        sb[$];
    logic        chk;
    logic [15:0] sysm;
    int          n_tests;
    int          n_fail;

    gb_timer_bank #(
        .NUM_CH    (NUM_CH),
        .SYS_W     (16),
        .BASE_ADDR (16'hFF04),
        .RELOAD_DLY(4),
        .SYS_RST   (SYS_RST)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .we   (we),
        .wdata(wdata),
        .rdata(rdata),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one comparison per presented read cycle.
    always @(negedge clk) begin
        if (chk) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underrun: got rdata=%02h irq=%b, required a queued entry", rdata, irq);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rdata !== e.data || irq !== e.irq) begin
                    n_fail++;
                    $display("FAIL %s (sys=%04h): got rdata=%02h irq=%b, required rdata=%02h irq=%b",
                             e.name, sysm, rdata, irq, e.data, e.irq);
                end
            end
        end
    end

    // Advances one clock; sysm tracks the system counter value visible in the new cycle.
    task automatic adv(input bit div_wr);
        @(posedge clk);
        if (rst)         sysm = 16'(SYS_RST);
        else if (div_wr) sysm = 16'h0000;
        else             sysm = sysm + 16'h0001;
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        chk   = 1'b0;
        adv(a == A_DIV);
        we    = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] d, input logic [NUM_CH-1:0] ei,
                      input string nm);
        exp_t e;
        e.name = nm;
        e.data = d;
        e.irq  = ei;
        sb.push_back(e);
        addr = a;
        we   = 1'b0;
        chk  = 1'b1;
        adv(1'b0);
        chk  = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        we  = 1'b0;
        chk = 1'b0;
        for (int i = 0; i < cycles; i++) adv(1'b0);
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        chk     = 1'b0;
        addr    = 16'h0000;
        we      = 1'b0;
        wdata   = 8'h00;
        rst     = 1'b1;
        sysm    = 16'(SYS_RST);

        // Reset state and address map.
        do_reset(2);
        rd(A_TIMA0, 8'h00, 2'b00, "rst_tima0");
        rd(A_TMA0,  8'h00, 2'b00, "rst_tma0");
        rd(A_TAC0,  8'hF8, 2'b00, "rst_tac0");
        rd(A_TAC1,  8'hF8, 2'b00, "rst_tac1");
        rd(A_STAT,  STAT_RST, 2'b00, "rst_status");
        rd(16'hFF06, 8'hFF, 2'b00, "unmapped_ff06");
        rd(16'hFF07, 8'hFF, 2'b00, "unmapped_ff07");
        rd(16'hFF0B, 8'hFF, 2'b00, "unmapped_ff0b");
        rd(16'hFF0F, 8'hFF, 2'b00, "unmapped_ff0f");
        rd(16'hFF03, 8'hAA, 2'b00, "outside_ff03");
        rd(16'hFF10, 8'hAA, 2'b00, "outside_ff10");

        // DIV after a fresh reset: 0x00 until sys reaches 0x0100, 252 cycles after reset.
        do_reset(1);
        for (int i = 0; i < 256; i++) begin
            rd(A_DIV, (i < 252) ? 8'h00 : 8'h01, 2'b00, "div_count");
        end

        // Channel 0 counts every 16 cycles; channel 1 stays idle.
        wr(A_DIV, 8'h5A);
        wr(A_TIMA0, 8'h00);
        wr(A_TAC0, 8'h05);
        while (sysm != 16'd50) begin
            if (sysm[2:0] == 3'd5) rd(A_TIMA1, 8'h00, 2'b00, "ch1_idle");
            else                   rd(A_TIMA0, 8'((sysm - 16'd1) >> 4), 2'b00, "ch0_count16");
        end

        // Overflow: four cycles of 0x00, then TMA with a single aligned irq pulse.
        wr(A_TAC0, 8'h00);
        wr(A_TMA0, 8'hAB);
        wr(A_TIMA0, 8'hFF);
        wr(A_DIV, 8'h00);
        wr(A_TAC0, 8'h05);
        while (sysm != 16'd35) begin
            rd(A_TIMA0,
               (sysm <= 16'd16) ? 8'hFF : (sysm <= 16'd20) ? 8'h00 : (sysm <= 16'd32) ? 8'hAB : 8'hAC,
               (sysm == 16'd21) ? 2'b01 : 2'b00, "ovf_reload");
        end

        // TIMA write during the second DELAY cycle cancels reload and irq.
        wr(A_TAC0, 8'h00);
        wr(A_TIMA0, 8'hFF);
        wr(A_DIV, 8'h00);
        wr(A_TAC0, 8'h05);
        while (sysm != 16'd18) begin
            rd(A_TIMA0, (sysm <= 16'd16) ? 8'hFF : 8'h00, 2'b00, "delay_pre_write");
        end
        wr(A_TIMA0, 8'h10);
        while (sysm != 16'd37) begin
            rd(A_TIMA0, (sysm <= 16'd32) ? 8'h10 : 8'h11, 2'b00, "delay_write_cancel");
        end

        // DIV write while the tapped bit is 1 gives exactly one extra tick.
        wr(A_TAC0, 8'h00);
        wr(A_TIMA0, 8'h40);
        wr(A_DIV, 8'h00);
        wr(A_TAC0, 8'h05);
        while (sysm != 16'd9) rd(A_TIMA0, 8'h40, 2'b00, "div_glitch_pre");
        wr(A_DIV, 8'hFF);
        do begin
            rd(A_TIMA0, (sysm == 16'd0) ? 8'h40 : (sysm <= 16'd16) ? 8'h41 : 8'h42, 2'b00, "div_glitch");
        end while (sysm != 16'd18);
        rd(A_DIV, 8'h00, 2'b00, "div_after_write");

        // Both channels overflow together: one irq=11 cycle, then sticky status.
        wr(A_TAC0, 8'h00);
        wr(A_TIMA0, 8'hFF);
        wr(A_TIMA1, 8'hFF);
        wr(A_TMA1, 8'h5C);
        wr(A_DIV, 8'h00);
        wr(A_TAC0, 8'h05);
        wr(A_TAC1, 8'h05);
        while (sysm != 16'd24) begin
            if (sysm == 16'd22) begin
                rd(A_TIMA0, 8'hAB, 2'b00, "dual_ch0");
            end else begin
                rd(A_TIMA1, (sysm <= 16'd16) ? 8'hFF : (sysm <= 16'd20) ? 8'h00 : 8'h5C,
                   (sysm == 16'd21) ? 2'b11 : 2'b00, "dual_ch1");
            end
        end
        rd(A_STAT, 8'hFF, 2'b00, "status_set");
        wr(A_STAT, 8'h01);
        rd(A_STAT, STAT_CLR, 2'b00, "status_clear");

        // TMA write on the RELOAD edge is what TIMA loads.
        wr(A_TAC1, 8'h00);
        wr(A_TAC0, 8'h00);
        wr(A_TIMA0, 8'hFF);
        wr(A_DIV, 8'h00);
        wr(A_TAC0, 8'h05);
        while (sysm != 16'd20) begin
            rd(A_TIMA0, (sysm <= 16'd16) ? 8'hFF : 8'h00, 2'b00, "reload_tma_pre");
        end
        wr(A_TMA0, 8'h77);
        rd(A_TIMA0, 8'h77, 2'b01, "reload_tma_irq");
        rd(A_TIMA0, 8'h77, 2'b00, "reload_tma_after");
        rd(A_TMA0,  8'h77, 2'b00, "reload_tma_reg");

        // Reset in the middle of DELAY: no reload, no irq.
        wr(A_TAC0, 8'h00);
        wr(A_TIMA0, 8'hFF);
        wr(A_DIV, 8'h00);
        wr(A_TAC0, 8'h05);
        while (sysm != 16'd18) begin
            rd(A_TIMA0, (sysm <= 16'd16) ? 8'hFF : 8'h00, 2'b00, "rst_delay_pre");
        end
        do_reset(1);
        for (int i = 0; i < 8; i++) rd(A_TIMA0, 8'h00, 2'b00, "rst_delay_no_irq");
        rd(A_TAC0, 8'hF8, 2'b00, "rst_delay_tac0");
        rd(A_TMA1, 8'h00, 2'b00, "rst_delay_tma1");
        rd(A_STAT, STAT_RST, 2'b00, "rst_delay_status");

        adv(1'b0);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
